// File: rtl/ssd_display_driver.sv
// Purpose : 13-bit binary -> 4-digit BCD (sequential double-dabble) and multiplexed 7-seg scan.
// Latency : num sampled in IDLE cycle N, bcd_q valid from N+15; pins lag idx/bcd_q by one cycle.
// Backpres: none; free-running converter, num changes outside the IDLE sample cycle are ignored.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   rst    in   1   synchronous, active-low reset
//   num    in  13   binary value to display (0..8191)
//   anode  out  4   digit enables, active-low, one-hot-low; anode[0] = units digit
//   seg    out  7   segments {g,f,e,d,c,b,a}, active-low
//   busy   out  1   high while the converter is in SHIFT or DONE
//
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always lit).
// Parameter REFRESH_CNT (>=2) is the number of clk cycles each digit slot lasts.

module ssd_display_driver #(
  parameter int REFRESH_CNT = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] num,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        busy
);

  localparam int CNT_W = (REFRESH_CNT > 2) ? $clog2(REFRESH_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // ---------------------------------------------------------------
  // Converter state
  // ---------------------------------------------------------------
  state_t      state_q, state_d;
  // sr[28:13] holds the four BCD nibbles being built, sr[12:0] the
  // binary bits still to be shifted in (MSB first).
  logic [28:0] sr_q, sr_d;
  logic [28:0] sr_adj;
  logic [3:0]  iter_q, iter_d;
  logic [15:0] bcd_q, bcd_d;
  logic        busy_q, busy_d;

  // ---------------------------------------------------------------
  // Scan state
  // ---------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       anode_q, anode_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       cur_nib;
  logic             blank;
  logic             slot_end;

  // Double-dabble correction: a nibble of 5 or more would exceed 9 after
  // the following shift, so pre-add 3 to make it carry into the next digit.
  function automatic logic [3:0] dabble(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // Active-low gfedcba patterns; non-decimal nibbles blank the digit.
  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------
  // Converter next-state logic
  // ---------------------------------------------------------------
  always_comb begin
    sr_adj = {dabble(sr_q[28:25]), dabble(sr_q[24:21]),
              dabble(sr_q[20:17]), dabble(sr_q[16:13]), sr_q[12:0]};
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;

    case (state_q)
      ST_IDLE: begin
        // Only point where num is observed.
        sr_d    = {16'h0000, num};
        iter_d  = 4'd0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        // The top bit of sr_adj is always 0 for a 13-bit input, so the
        // shift never loses a significant digit bit.
        sr_d   = sr_adj << 1;
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd12) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Whole 16-bit result lands at once so the scan never shows a
        // half-converted value.
        bcd_d   = sr_q[28:13];
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // busy is registered but tracks the state register exactly.
    busy_d = (state_d != ST_IDLE);
  end

  // ---------------------------------------------------------------
  // Scan next-state logic (independent of the converter)
  // ---------------------------------------------------------------
  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    cnt_d    = slot_end ? '0 : (cnt_q + CNT_W'(1));
    idx_d    = slot_end ? (idx_q + 2'd1) : idx_q;

    case (idx_q)
      2'd0:    cur_nib = bcd_q[3:0];
      2'd1:    cur_nib = bcd_q[7:4];
      2'd2:    cur_nib = bcd_q[11:8];
      default: cur_nib = bcd_q[15:12];
    endcase

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit above it are 0.
    case (idx_q)
      2'd0:    blank = 1'b0;
      2'd1:    blank = (bcd_q[15:4] == 12'h000);
      2'd2:    blank = (bcd_q[15:8] == 8'h00);
      default: blank = (bcd_q[15:12] == 4'h0);
    endcase
`else
    blank = 1'b0;
`endif

    anode_d = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d   = blank ? 7'b1111111 : decode(cur_nib);
  end

  // ---------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      iter_q  <= 4'd0;
      bcd_q   <= 16'h0000;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      anode_q <= 4'b1111;
      seg_q   <= 7'b1111111;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
    end
  end

  assign anode = anode_q;
  assign seg   = seg_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_ssd_display_driver.sv
// Bench for ssd_display_driver with a short refresh slot. The reference
// model works in plain decimal arithmetic: the value on display is the
// num present at every 15th clock edge after reset, published 14 edges
// later; the lit digit advances every 4 edges.

module tb_ssd_display_driver;

  localparam int REFRESH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [12:0] num = 13'd0;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        busy;

  ssd_display_driver #(.REFRESH_CNT(REFRESH)) dut (
    .clk   (clk),
    .rst   (rst),
    .num   (num),
    .anode (anode),
    .seg   (seg),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state
  int e      = 0;  // index of the next clock edge since reset release
  int latched = 0; // value sampled by the converter
  int shown  = 0;  // value currently published to the display

  logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  function automatic int pow10(input int i);
    int r = 1;
    for (int k = 0; k < i; k++) r = r * 10;
    return r;
  endfunction

  function automatic int to_bcd(input int v);
    return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  // One clock: advance the model across the edge and compare all outputs.
  task automatic step();
    int         idx;
    int         d;
    bit         blank;
    logic [3:0] ea;
    logic [6:0] es;
    @(posedge clk);
    #1;
    if (rst == 1'b0) begin
      e     = 0;
      shown = 0;
      check_val("rst_anode", 32'(anode), 32'h0000000F);
      check_val("rst_seg",   32'(seg),   32'h0000007F);
      check_val("rst_busy",  32'(busy),  32'h00000000);
      check_val("rst_bcd",   32'(dut.bcd_q), 32'h00000000);
    end else begin
      // Pins reflect the digit index and value held before this edge.
      idx   = (e / REFRESH) % 4;
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank = (idx > 0) && (shown < pow10(idx));
`endif
      d  = (shown / pow10(idx)) % 10;
      ea = blank ? 4'b1111 : ~(4'b0001 << idx);
      es = blank ? 7'b1111111 : seg_tbl[d];
      if (e % 15 == 0)  latched = num;
      if (e % 15 == 14) shown   = latched;
      check_val("anode", 32'(anode), 32'(ea));
      check_val("seg",   32'(seg),   32'(es));
      check_val("busy",  32'(busy),  32'((e % 15) != 14));
      check_val("bcd",   32'(dut.bcd_q), 32'(to_bcd(shown)));
      e++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the next edge to be processed has the given phase.
  task automatic run_until(input int ph);
    for (int i = 0; i < 20 && (e % 15) != ph; i++) step();
    check_val("align", 32'(e % 15), 32'(ph));
  endtask

  initial begin
    // Reset held for two edges, then release.
    rst = 1'b0;
    num = 13'd0;
    run(2);
    rst = 1'b1;
    run(3);

    // Steady value, full scan of all four digits several times.
    num = 13'd1234;
    run(48);

    // Range extremes.
    num = 13'd8191;
    run(32);
    num = 13'd0;
    run(32);

    // Input change during the 3rd SHIFT cycle must not corrupt 1234.
    num = 13'd1234;
    run(16);
    run_until(3);
    num = 13'd5678;
    run(40);

    // Reset pulse at the end of the 5th SHIFT cycle.
    num = 13'd4321;
    run(16);
    run_until(5);
    rst = 1'b0;
    step();
    rst = 1'b1;
    run(40);

    // Leading-zero cases.
    num = 13'd7;
    run(40);
    num = 13'd0;
    run(32);
    num = 13'd1005;
    run(40);
    num = 13'd90;
    run(32);

    // Randomized: random values held for random spans, occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(11, 0) == 0) num = 13'($urandom_range(8191, 0));
      if ($urandom_range(199, 0) == 0) begin
        rst = 1'b0;
        step();
        if ($urandom_range(1, 0) == 1) step();
        rst = 1'b1;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
